activation_pwl: RTL and testbench
=================================

# activation_pwl

Pipelined, parametrised activation unit for the denoiser datapath. It computes sigmoid, hard-sigmoid, ReLU and (optionally) tanh on signed fixed-point samples using a shift-and-add piecewise-linear (PLAN) approximation, so no multipliers are used. It sits between the MAC/accumulator stage and the layer output buffer, and uses a valid/ready stream on both sides so it can absorb backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 16: input/output sample width, two's complement.
- `FRACT_WIDTH`, 8: fractional bits of the input and output Q format. Must be ≥ 5 and ≤ `DATA_WIDTH`-4.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the input sample is valid.
- `in_ready` out 1: the block accepts a sample this cycle.
- `in_data` in `DATA_WIDTH`: signed input x.
- `in_mode` in 2: function select, sampled with `in_data`.
  - 0 = sigmoid (PLAN)
  - 1 = hard sigmoid
  - 2 = tanh
  - 3 = ReLU
- `out_valid` out 1: the output sample is valid.
- `out_ready` in 1: downstream accepts the output.
- `out_data` out `DATA_WIDTH`: the result, same Q format as the input.

## Operation
- A transfer happens when valid and ready are both high at a rising edge. The mode travels with its sample, so the mode may change on every sample.
- PLAN sigmoid, with a = |x|:
  - a ≥ 5: y = 1.
  - 2.375 ≤ a < 5: y = a>>5 + 0.84375.
  - 1 ≤ a < 2.375: y = a>>3 + 0.625.
  - a < 1: y = a>>2 + 0.5.
  - For x < 0, y = 1 − y(a).
- Each segment's lower bound is inclusive.
- For x = most-negative, a saturates to max-positive.
- All shifts are logical on the non-negative a and truncate.
- Hard sigmoid:
  - x ≤ −2 gives 0.
  - x ≥ 2 gives 1.
  - Otherwise y = (x+2)>>>2, arithmetic shift.
- ReLU: y = x if x > 0, else 0.
- Tanh: y = 2·sigmoid(2x) − 1.
  - 2x saturates to the `DATA_WIDTH` signed range.
  - The result is signed, in the range [−1, 1].
- Constants (1, 0.5, 0.625, 0.84375, 2, 2.375, 5) are scaled by 2^`FRACT_WIDTH` at elaboration.
- Internal sums use `DATA_WIDTH`+1 bits. The final result is clamped to [0, 1] (sigmoid modes) or [−1, 1] (tanh) before output.

## Timing
- Three-stage pipeline:
  - S1: register x and mode, form a, select the segment.
  - S2: shift and add.
  - S3: negative-side fold, tanh post-process, clamp.
- Latency is exactly 3 cycles from the accepting edge to `out_valid`, when there are no stalls.
- Throughput is 1 sample per cycle.
- Each stage advances when it is empty or the stage after it advances.
  - `in_ready` = !S1_valid | S1 advance. It is combinational from `out_ready` through the stage valids.
  - Up to 3 samples are in flight. If `out_ready` stays low, `in_ready` falls after S1–S3 fill.
- While `out_valid` is high and `out_ready` is low, `out_data` is held stable.
- Order is preserved; no sample is dropped or duplicated.
- A simultaneous accept and emit in the same cycle with a full pipeline must not bubble.
- Reset (asserted at any time, including mid-stream):
  - All stage valids clear to 0 immediately and in-flight samples are discarded.
  - `out_valid` = 0, `out_data` = 0, `in_ready` = 1.
  - After reset is released, the first accept happens on the next edge where `in_valid` is high.

## Configuration
- `ACTIVATION_TANH_EN`
  - Defined: mode 2 computes tanh as above.
  - Undefined: the tanh pre-scale and post-process logic is not built, and mode 2 behaves exactly like mode 0 (sigmoid). Latency is unchanged.

## Structure
- Shared package `activation_pkg` holds:
  - the mode encoding constants `ACT_SIGMOID`, `ACT_HARD`, `ACT_TANH`, `ACT_RELU`;
  - the PLAN breakpoints and offsets, expressed as functions of `FRACT_WIDTH`;
  - a per-stage payload typedef (valid, mode, sign, data).
- One sub-module, `plan_segment`: combinational segment select plus shift-add for a ≥ 0. It is instantiated in S1/S2.

## Test plan
Q8.8 format, default parameters. The tanh case is with `ACTIVATION_TANH_EN` defined.
- Sigmoid spot values:
  - x = 0x0000 → 0x0080.
  - x = 0x0100 → 0x00C0.
  - x = 0xFF00 → 0x0040.
  - x = 0x0600 → 0x0100.
  - x = 0x8000 → 0x0000.
  - Each appears 3 cycles after acceptance.
- Hard sigmoid and ReLU:
  - hard, x = 0x0100 → 0x00C0.
  - hard, x = 0xFD00 → 0x0000.
  - ReLU, x = 0xFF80 → 0x0000.
  - ReLU, x = 0x0280 → 0x0280.
- Tanh:
  - x = 0x0080 → 0x0080.
  - x = 0xFF80 → 0xFF80.
  - x = 0x0400 → 0x0100.
  - Without the macro, mode 2 with x = 0x0100 → 0x00C0.
- Backpressure:
  - Setup: stream 8 samples with alternating modes, `out_ready` = 0 for 6 cycles, then 1.
  - `in_ready` drops after 3 accepts.
  - `out_data` stays stable while stalled.
  - All 8 results arrive in order and match the reference model.
- Full throughput: continuous `in_valid` and `out_ready` for 64 random samples gives one output per cycle with no bubbles.
- Reset mid-stream: drive `reset` low with 2 samples in flight. Required response:
  - `out_valid` falls asynchronously.
  - After release, only newly accepted samples appear.

Source files
------------

// File: rtl/activation_pkg.sv
// Shared mode encodings, PLAN segment constants and the stage payload type
// for the piecewise-linear activation unit.
package activation_pkg;

  // Wide enough for DATA_WIDTH+1 bit sums for any DATA_WIDTH up to 30.
  localparam int ACT_PAYLOAD_W = 32;

  typedef enum logic [1:0] {
    ACT_SIGMOID = 2'd0,
    ACT_HARD    = 2'd1,
    ACT_TANH    = 2'd2,
    ACT_RELU    = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    SEG_LO,
    SEG_MID,
    SEG_HI,
    SEG_SAT
  } plan_seg_e;

  typedef struct packed {
    logic                            valid;
    act_mode_e                       mode;
    logic                            sign;
    logic signed [ACT_PAYLOAD_W-1:0] data;
  } act_stage_t;

  // Q-format constants; fw is the number of fractional bits (>= 5).
  function automatic int act_one(input int fw);
    return 1 << fw;
  endfunction

  function automatic int act_half(input int fw);
    return 1 << (fw - 1);
  endfunction

  function automatic int act_two(input int fw);
    return 2 << fw;
  endfunction

  function automatic int act_off_mid(input int fw);
    return 5 << (fw - 3);
  endfunction

  function automatic int act_off_hi(input int fw);
    return 27 << (fw - 5);
  endfunction

  function automatic int act_bp_hi(input int fw);
    return 19 << (fw - 3);
  endfunction

  function automatic int act_bp_sat(input int fw);
    return 5 << fw;
  endfunction

endpackage

// File: rtl/activation_pwl_plan_segment.sv
// PLAN sigmoid core for a non-negative magnitude: picks the segment and
// evaluates it with a shift and a constant add.
module plan_segment
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH:0]   y
);

  localparam logic [DATA_WIDTH-1:0] BP_MID = DATA_WIDTH'(act_one(FRACT_WIDTH));
  localparam logic [DATA_WIDTH-1:0] BP_HI  = DATA_WIDTH'(act_bp_hi(FRACT_WIDTH));
  localparam logic [DATA_WIDTH-1:0] BP_SAT = DATA_WIDTH'(act_bp_sat(FRACT_WIDTH));

  localparam logic [DATA_WIDTH:0] OFF_LO  = (DATA_WIDTH+1)'(act_half(FRACT_WIDTH));
  localparam logic [DATA_WIDTH:0] OFF_MID = (DATA_WIDTH+1)'(act_off_mid(FRACT_WIDTH));
  localparam logic [DATA_WIDTH:0] OFF_HI  = (DATA_WIDTH+1)'(act_off_hi(FRACT_WIDTH));
  localparam logic [DATA_WIDTH:0] Y_ONE   = (DATA_WIDTH+1)'(act_one(FRACT_WIDTH));

  plan_seg_e           seg;
  logic [DATA_WIDTH:0] a_ext;

  assign a_ext = {1'b0, a};

  // Lower bound of every segment is inclusive.
  always_comb begin
    seg = SEG_LO;
    if (a >= BP_SAT)      seg = SEG_SAT;
    else if (a >= BP_HI)  seg = SEG_HI;
    else if (a >= BP_MID) seg = SEG_MID;
  end

  always_comb begin
    y = Y_ONE;
    case (seg)
      SEG_LO:  y = (a_ext >> 2) + OFF_LO;
      SEG_MID: y = (a_ext >> 3) + OFF_MID;
      SEG_HI:  y = (a_ext >> 5) + OFF_HI;
      default: y = Y_ONE;
    endcase
  end

endmodule

// File: rtl/activation_pwl.sv
// Three-stage valid/ready activation unit: sigmoid (PLAN), hard sigmoid, ReLU
// and, when ACTIVATION_TANH_EN is defined, tanh; otherwise mode 2 is sigmoid.
module activation_pwl
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef logic signed [ACT_PAYLOAD_W-1:0] wide_t;

  localparam wide_t ONE  = wide_t'(act_one(FRACT_WIDTH));
  localparam wide_t TWO  = wide_t'(act_two(FRACT_WIDTH));
  localparam wide_t DMAX = wide_t'((1 << (DATA_WIDTH - 1)) - 1);

  localparam logic [DATA_WIDTH-1:0] A_MAX  = DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic [DATA_WIDTH-1:0] ONE_DW = DATA_WIDTH'(act_one(FRACT_WIDTH));
`ifdef ACTIVATION_TANH_EN
  localparam wide_t                 DMIN       = -DMAX - 1;
  localparam logic [DATA_WIDTH-1:0] NEG_ONE_DW = DATA_WIDTH'(-act_one(FRACT_WIDTH));
`endif

  act_stage_t            s1, s2;
  logic                  s1_load, s2_load, s3_load;
  wide_t                 xs, mag, s2_res, fold;
  logic [DATA_WIDTH-1:0] a, s3_res;
  logic [DATA_WIDTH:0]   plan_y;

  // A stage loads when it is empty or its content moves on this edge.
  assign s3_load  = !out_valid || out_ready;
  assign s2_load  = !s2.valid || s3_load;
  assign s1_load  = !s1.valid || s2_load;
  assign in_ready = s1_load;

  // Magnitude for the PLAN core; the most-negative input saturates.
  always_comb begin
    xs = s1.data;
`ifdef ACTIVATION_TANH_EN
    if (s1.mode == ACT_TANH) begin
      xs = s1.data <<< 1;
      if (xs > DMAX)      xs = DMAX;
      else if (xs < DMIN) xs = DMIN;
    end
`endif
    mag = s1.sign ? -xs : xs;
    a   = (mag > DMAX) ? A_MAX : mag[DATA_WIDTH-1:0];
  end

  plan_segment #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_plan_segment (
    .a (a),
    .y (plan_y)
  );

  always_comb begin
    s2_res = wide_t'(plan_y);
    case (s1.mode)
      ACT_HARD: begin
        if (s1.data <= -TWO)     s2_res = '0;
        else if (s1.data >= TWO) s2_res = ONE;
        else                     s2_res = (s1.data + TWO) >>> 2;
      end
      ACT_RELU: s2_res = (s1.data > 0) ? s1.data : '0;
      default:  ;
    endcase
  end

  // Negative-side fold, tanh rescale and final range clamp.
  always_comb begin
    fold = s2.data;
    if (s2.mode != ACT_HARD && s2.mode != ACT_RELU && s2.sign)
      fold = ONE - s2.data;
`ifdef ACTIVATION_TANH_EN
    if (s2.mode == ACT_TANH)
      fold = (fold <<< 1) - ONE;
`endif
    s3_res = fold[DATA_WIDTH-1:0];
    case (s2.mode)
      ACT_RELU: ;
`ifdef ACTIVATION_TANH_EN
      ACT_TANH: begin
        if (fold > ONE)       s3_res = ONE_DW;
        else if (fold < -ONE) s3_res = NEG_ONE_DW;
      end
`endif
      default: begin
        if (fold > ONE)    s3_res = ONE_DW;
        else if (fold < 0) s3_res = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= '0;
      s2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (s1_load) begin
        s1.valid <= in_valid;
        if (in_valid) begin
          s1.mode <= act_mode_e'(in_mode);
          s1.sign <= in_data[DATA_WIDTH-1];
          s1.data <= wide_t'(signed'(in_data));
        end
      end
      if (s2_load) begin
        s2.valid <= s1.valid;
        if (s1.valid) begin
          s2.mode <= s1.mode;
          s2.sign <= s1.sign;
          s2.data <= s2_res;
        end
      end
      if (s3_load) begin
        out_valid <= s2.valid;
        if (s2.valid) out_data <= s3_res;
      end
    end
  end

endmodule

// File: tb/tb_activation_pwl.sv
// Scoreboard bench for activation_pwl in Q8.8; tanh expectations follow
// ACTIVATION_TANH_EN.
module tb_activation_pwl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [1:0]  m;
    logic [15:0] x;
    logic [15:0] y;
  } spot_t;

  always #5 clk = ~clk;

  activation_pwl #(
    .DATA_WIDTH  (16),
    .FRACT_WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Reference PLAN sigmoid in plain integer Q8.8 arithmetic.
  function automatic int sig_ref(input int x);
    int a, y;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    if (a >= 1280)     y = 256;
    else if (a >= 608) y = a / 32 + 216;
    else if (a >= 256) y = a / 8 + 160;
    else               y = a / 4 + 128;
    if (x < 0) y = 256 - y;
    return y;
  endfunction

  function automatic logic [15:0] model(input int mode, input logic [15:0] raw);
    int x, r;
    x = int'($signed(raw));
    case (mode)
      1: r = (x <= -512) ? 0 : (x >= 512) ? 256 : (x + 512) / 4;
      3: r = (x > 0) ? x : 0;
`ifdef ACTIVATION_TANH_EN
      2: begin
        int x2;
        x2 = 2 * x;
        if (x2 > 32767)  x2 = 32767;
        if (x2 < -32768) x2 = -32768;
        r = 2 * sig_ref(x2) - 256;
      end
`endif
      default: r = sig_ref(x);
    endcase
    return 16'(r);
  endfunction

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
    compared++;
    if (out_data !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL reset_out_data: got %h want 0000", out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release_out_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_spot_values();
    spot_t       tbl[$];
    logic [15:0] want;
    int          lat;
    bit          got;
    exp_q.delete();
    tbl.push_back('{2'd0, 16'h0000, 16'h0080});
    tbl.push_back('{2'd0, 16'h0100, 16'h00C0});
    tbl.push_back('{2'd0, 16'hFF00, 16'h0040});
    tbl.push_back('{2'd0, 16'h0600, 16'h0100});
    tbl.push_back('{2'd0, 16'h8000, 16'h0000});
    tbl.push_back('{2'd1, 16'h0100, 16'h00C0});
    tbl.push_back('{2'd1, 16'hFD00, 16'h0000});
    tbl.push_back('{2'd3, 16'hFF80, 16'h0000});
    tbl.push_back('{2'd3, 16'h0280, 16'h0280});
`ifdef ACTIVATION_TANH_EN
    tbl.push_back('{2'd2, 16'h0080, 16'h0080});
    tbl.push_back('{2'd2, 16'hFF80, 16'hFF80});
    tbl.push_back('{2'd2, 16'h0400, 16'h0100});
`else
    tbl.push_back('{2'd2, 16'h0100, 16'h00C0});
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_mode   = tbl[i].m;
      in_data   = tbl[i].x;
      out_ready = 1'b1;
      @(negedge clk);
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL spot%0d_in_ready: got %b want 1", i, in_ready);
      end
      exp_q.push_back(tbl[i].y);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 8) begin
        @(negedge clk);
        lat++;
        if (out_valid === 1'b1) begin
          got = 1'b1;
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            compared++;
            if (out_data !== want) begin
              mismatched++;
              $display("[TB] FAIL spot%0d_data mode %0d x %h: got %h want %h",
                       i, tbl[i].m, tbl[i].x, out_data, want);
            end
          end
        end
      end
      // Output seen in the 3rd cycle after accept transfers on the 3rd edge.
      compared++;
      if (!got || lat != 3) begin
        mismatched++;
        $display("[TB] FAIL spot%0d_latency: got %0d edges (seen=%0b) want 3", i, lat, got);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] bp_x [8];
    logic [15:0] want;
    int          sent, recv, cyc, stall_accepts;
    bp_x = '{16'h0100, 16'hFE80, 16'h0300, 16'hFF40,
             16'h0700, 16'h0180, 16'hFC00, 16'h0050};
    exp_q.delete();
    sent = 0;
    recv = 0;
    cyc  = 0;
    stall_accepts = 0;
    while (recv < 8 && cyc < 80) begin
      @(posedge clk);
      #1;
      out_ready = (cyc >= 6);
      in_valid  = (sent < 8);
      in_mode   = 2'(sent % 4);
      in_data   = bp_x[sent % 8];
      @(negedge clk);
      if (cyc < 6) begin
        compared++;
        if (in_ready !== (cyc < 3)) begin
          mismatched++;
          $display("[TB] FAIL bp_in_ready cyc %0d: got %b want %b", cyc, in_ready, (cyc < 3));
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL bp_unexpected: got %h want none", out_data);
        end else begin
          want = exp_q.pop_front();
          compared++;
          if (out_data !== want) begin
            mismatched++;
            $display("[TB] FAIL bp_data%0d: got %h want %h", recv, out_data, want);
          end
          recv++;
        end
      end else if (out_valid === 1'b1 && exp_q.size() > 0) begin
        compared++;
        if (out_data !== exp_q[0]) begin
          mismatched++;
          $display("[TB] FAIL bp_hold cyc %0d: got %h want %h", cyc, out_data, exp_q[0]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(in_mode), in_data));
        sent++;
        if (!out_ready) stall_accepts++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    compared++;
    if (stall_accepts != 3) begin
      mismatched++;
      $display("[TB] FAIL bp_stall_accepts: got %0d want 3", stall_accepts);
    end
    compared++;
    if (recv != 8) begin
      mismatched++;
      $display("[TB] FAIL bp_received: got %0d want 8", recv);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    int          sent, recv, cyc, first_out, bubbles, stalls;
    exp_q.delete();
    sent = 0;
    recv = 0;
    cyc  = 0;
    first_out = -1;
    bubbles = 0;
    stalls  = 0;
    out_ready = 1'b1;
    while (recv < 64 && cyc < 200) begin
      @(posedge clk);
      #1;
      if (sent < 64) begin
        in_valid = 1'b1;
        in_mode  = 2'($urandom_range(0, 3));
        in_data  = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (first_out < 0) first_out = cyc;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL b2b_unexpected: got %h want none", out_data);
        end else begin
          want = exp_q.pop_front();
          compared++;
          if (out_data !== want) begin
            mismatched++;
            $display("[TB] FAIL b2b_data%0d: got %h want %h", recv, out_data, want);
          end
        end
        recv++;
      end else if (recv > 0 && recv < 64) begin
        bubbles++;
      end
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(in_mode), in_data));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    compared++;
    if (recv != 64) begin
      mismatched++;
      $display("[TB] FAIL b2b_received: got %0d want 64", recv);
    end
    compared++;
    if (bubbles != 0 || stalls != 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_bubbles: got %0d bubbles %0d stalls want 0 0", bubbles, stalls);
    end
    compared++;
    if (first_out != 3) begin
      mismatched++;
      $display("[TB] FAIL b2b_first_out: got cycle %0d want 3", first_out);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] nx [2];
    logic [15:0] want;
    int          sent, recv, extra, cyc;
    nx = '{16'h0123, 16'h0456};
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_mode  = 2'd0;
      in_data  = (i == 0) ? 16'h0100 : 16'h0200;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_pre_valid: got %b want 1", out_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_async_valid: got %b want 0", out_valid);
    end
    compared++;
    if (out_data !== 16'h0000 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_async_state: got data %h ready %b want 0000 1", out_data, in_ready);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sent  = 0;
    recv  = 0;
    extra = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (sent < 2) begin
        in_valid = 1'b1;
        in_mode  = 2'd3;
        in_data  = nx[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          want = exp_q.pop_front();
          compared++;
          if (out_data !== want) begin
            mismatched++;
            $display("[TB] FAIL mid_data%0d: got %h want %h", recv, out_data, want);
          end
          recv++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(in_mode), in_data));
        sent++;
      end
    end
    in_valid = 1'b0;
    compared++;
    if (recv != 2 || extra != 0) begin
      mismatched++;
      $display("[TB] FAIL mid_after_reset: got %0d new %0d extra want 2 0", recv, extra);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] activation_pwl bench start");
    test_reset();
    test_spot_values();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
